// File: rtl/decode_buffer_if.sv
// Fetch/decode handshake bundle for the decode buffer.
// The master side is fetch plus decode; the slave side is the buffer.
interface decode_buffer_if #(
   parameter int DEPTH  = 4,
   parameter int PC_W   = 32,
   parameter int INST_W = 32,
   parameter int CNT_W  = $clog2(DEPTH) + 1
);
   logic              in_valid;
   logic              in_ready;
   logic [PC_W-1:0]   in_pc;
   logic [INST_W-1:0] in_inst;
   logic              out_valid;
   logic              out_ready;
   logic [PC_W-1:0]   out_pc;
   logic [INST_W-1:0] out_inst;
   logic              out_is_jb;
   logic              out_delay_slot;
   logic              out_adel;
   logic [CNT_W-1:0]  count;

   modport master (
      output in_valid, in_pc, in_inst, out_ready,
      input  in_ready, out_valid, out_pc, out_inst, out_is_jb,
             out_delay_slot, out_adel, count
   );

   modport slave (
      input  in_valid, in_pc, in_inst, out_ready,
      output in_ready, out_valid, out_pc, out_inst, out_is_jb,
             out_delay_slot, out_adel, count
   );
endinterface

// File: rtl/decode_buffer.sv
// Circular fetch-to-decode instruction queue with enqueue-time pre-decode
// (jump/branch, delay slot, misaligned PC) and whole-queue flush.
module decode_buffer #(
   parameter int DEPTH  = 4,
   parameter int PC_W   = 32,
   parameter int INST_W = 32
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           flush,
   decode_buffer_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [PC_W-1:0]   pc_q   [DEPTH];
   logic [INST_W-1:0] inst_q [DEPTH];
   logic              jb_q   [DEPTH];
   logic              ds_q   [DEPTH];
   logic              adel_q [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             last_jb_q, last_jb_d;

   logic in_ready, out_valid, enq, deq;
   logic pre_jb, pre_adel;

   function automatic logic is_jump_branch(input logic [INST_W-1:0] inst);
      logic [5:0] opcode;
      logic [4:0] rt;
      logic [5:0] funct;
      opcode = inst[31:26];
      rt     = inst[20:16];
      funct  = inst[5:0];
      case (opcode)
         6'b000010, 6'b000011,
         6'b000100, 6'b000101,
         6'b000110, 6'b000111: is_jump_branch = 1'b1;
         6'b000001: is_jump_branch = (rt == 5'b00000) || (rt == 5'b00001) ||
                                     (rt == 5'b10000) || (rt == 5'b10001);
         6'b000000: is_jump_branch = (funct == 6'b001000) || (funct == 6'b001001);
         default:   is_jump_branch = 1'b0;
      endcase
   endfunction

   // Ready/valid come only from registered state (plus flush/reset), never from the peer handshake.
   assign in_ready  = (count_q != CNT_W'(DEPTH)) & ~flush & ~reset;
   assign out_valid = (count_q != '0);
   assign enq       = bus.in_valid & in_ready;
   assign deq       = out_valid & bus.out_ready;

   assign pre_jb   = is_jump_branch(bus.in_inst);
   assign pre_adel = (bus.in_pc[1:0] != 2'b00);

   assign bus.in_ready       = in_ready;
   assign bus.out_valid      = out_valid;
   assign bus.out_pc         = pc_q[rd_ptr_q];
   assign bus.out_inst       = inst_q[rd_ptr_q];
   assign bus.out_is_jb      = jb_q[rd_ptr_q];
   assign bus.out_delay_slot = ds_q[rd_ptr_q];
   assign bus.out_adel       = adel_q[rd_ptr_q];
   assign bus.count          = count_q;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      last_jb_d = last_jb_q;
      if (flush) begin
         // A dequeue in the flush cycle is still taken by decode; the buffer simply forgets it.
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         count_d   = '0;
         last_jb_d = 1'b0;
      end else begin
         if (enq) begin
            wr_ptr_d  = wr_ptr_q + PTR_W'(1);
            last_jb_d = pre_jb;
         end
         if (deq) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         last_jb_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]   <= '0;
            inst_q[i] <= '0;
            jb_q[i]   <= 1'b0;
            ds_q[i]   <= 1'b0;
            adel_q[i] <= 1'b0;
         end
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         last_jb_q <= last_jb_d;
         if (enq) begin
            pc_q[wr_ptr_q]   <= bus.in_pc;
            inst_q[wr_ptr_q] <= bus.in_inst;
            jb_q[wr_ptr_q]   <= pre_jb;
            ds_q[wr_ptr_q]   <= last_jb_q;
            adel_q[wr_ptr_q] <= pre_adel;
         end
      end
   end
endmodule

// File: doc/decode_buffer.md
# decode_buffer

Parametrised instruction buffer between the fetch and decode stages. It queues up to DEPTH {pc, inst} pairs behind a valid/ready handshake and pre-decodes each entry as it is enqueued. The pre-decode marks jumps and branches, tags delay-slot instructions, and flags misaligned PCs. A flush on exception or redirect clears the whole queue, and decode can then stall without back-pressuring fetch combinationally.

## Interface
Parameters:
- DEPTH, default 4: number of entries. Must be a power of two and at least 2.
- PC_W, default 32: PC width.
- INST_W, default 32: instruction width. Must be 32 for the pre-decode to be valid.
- CNT_W, default $clog2(DEPTH)+1: occupancy counter width. Derived; do not override.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discards every stored entry and the delay-slot history.
- in_valid  in  1  fetch offers an entry.
- in_ready  out  1  the buffer accepts the offered entry.
- in_pc  in  PC_W  PC of the offered instruction.
- in_inst  in  INST_W  the offered instruction.
- out_valid  out  1  the head entry is valid.
- out_ready  in  1  decode consumes the head entry.
- out_pc  out  PC_W  PC of the head entry.
- out_inst  out  INST_W  instruction of the head entry.
- out_is_jb  out  1  the head entry is a jump or branch.
- out_delay_slot  out  1  the head entry is in a delay slot.
- out_adel  out  1  the head entry's PC is misaligned.
- count  out  CNT_W  number of valid entries.

## Operation
- Storage is a circular array of DEPTH entries. Each entry holds {pc, inst, is_jb, delay_slot, adel}.
- Read and write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- The enqueue handshake is in_valid & in_ready. The dequeue handshake is out_valid & out_ready.
- in_ready = (count != DEPTH) & ~flush. There is no full-bypass: with the buffer full, a simultaneous dequeue does not enable an enqueue in the same cycle.
- out_valid = (count != 0). All out_* fields are driven from the head entry.
- out_* fields are don't-care when out_valid = 0. The bench must not check them then.
- Pre-decode is computed from in_inst and in_pc at enqueue time:
  - is_jb covers opcode 000010 (J), 000011 (JAL), and 000100 through 000111 (BEQ, BNE, BLEZ, BGTZ).
  - It also covers opcode 000001 when inst[20:16] is 00000, 00001, 10000 or 10001.
  - It also covers opcode 000000 when inst[5:0] is 001000 (JR) or 001001 (JALR).
  - adel = (in_pc[1:0] != 2'b00).
  - delay_slot = last_jb, a register holding is_jb of the most recently enqueued entry.
- last_jb updates only on an accepted enqueue. It is cleared by reset and by flush.
- count updates as follows:
  - +1 on enqueue only.
  - −1 on dequeue only.
  - Unchanged when both happen in the same cycle.
- Flush, in the cycle it is asserted:
  - Pointers, count and last_jb go to 0 at the next edge.
  - Any dequeue handshake in that cycle is still consumed by decode; the buffer ignores it.
  - No enqueue occurs, because in_ready = 0.
- Reset has priority over flush, which has priority over enqueue and dequeue.

## Timing
- Reset values:
  - in_ready = 1 once reset deasserts; it is 0 while reset is high.
  - out_valid = 0, count = 0.
  - last_jb = 0, pointers = 0.
  - out_pc, out_inst, out_is_jb, out_delay_slot and out_adel = 0, because the storage array is cleared on reset.
- Latency: an entry enqueued at edge N appears on out_* with out_valid = 1 right after edge N. No same-cycle fall-through when the buffer is empty.
- Throughput: one enqueue and one dequeue per cycle, sustained when 0 < count < DEPTH.
- Full: in_ready drops in the cycle after the edge at which count reaches DEPTH.
- Empty: out_valid drops after the edge at which the last entry is dequeued.
- in_ready and out_valid depend only on registered state and flush, never combinationally on out_ready or in_valid.
- Reset mid-operation: all entries are lost, with identical results to flush.
- Pointer wrap: after DEPTH enqueues the write pointer returns to 0. Ordering is preserved across the wrap.

## Test plan
- Reset, then push 4 entries (pc 0x00, 0x04, 0x08, 0x0C) with out_ready = 0 and DEPTH = 4 -> count = 4 and in_ready = 0. Then pop all -> pcs are emitted in order and count = 0.
- Push BEQ 0x10220003 at pc 0x100, then ADDU at pc 0x104, then a third instruction at 0x108 -> out_is_jb is 1, 0, 0 and out_delay_slot is 0, 1, 0.
- Push at pc 0x202 -> out_adel = 1. A push at pc 0x204 -> out_adel = 0.
- Fill 3 entries, then assert flush for one cycle while in_valid = 1 -> count = 0, out_valid = 0, the input is not accepted, and the next enqueue has delay_slot = 0 even if the last flushed entry was JR 0x03E00008.
- Run continuous push/pop for 10 cycles with count = 1 -> count stays at 1, pointers wrap twice, and the pc sequence is intact.
- Assert reset while count = 2 -> all outputs return to their reset values at the next edge.
